m6502_alu_seq: RTL and testbench

M6502_ALU_SEQ -- requirements
Module: m6502_alu_seq

---
 rtl/m6502_alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_m6502_alu_seq.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6502_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : m6502_alu_seq
//  Purpose  : Sequences one ALU operation with optional memory read-operand
//             fetch and read-modify-write back, pulsing an external ALU.
//  Revision : 1.0
// ============================================================================
module m6502_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_imm,
    input  logic [1:0]  req_mode,
    input  logic [15:0] req_addr,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic [3:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_proceed,
    input  logic [7:0]  alu_out,
    output logic        busy,
    output logic        done,
    output logic [7:0]  result
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_READ  = 3'd1;
    localparam logic [2:0] c_ST_EXEC  = 3'd2;
    localparam logic [2:0] c_ST_WAIT  = 3'd3;
    localparam logic [2:0] c_ST_WRITE = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [1:0] c_MODE_MEM = 2'd1;
    localparam logic [1:0] c_MODE_RMW = 2'd2;

    logic [2:0]  r_state;
    logic [3:0]  r_op;
    logic [7:0]  r_a;
    logic [7:0]  r_imm;
    logic [1:0]  r_mode;
    logic [15:0] r_addr;

    logic [15:0] r_mem_addr;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [7:0]  r_mem_wdata;
    logic [3:0]  r_alu_op;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic        r_alu_proceed;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_result;

    logic        w_req_is_mem;

    assign w_req_is_mem = (req_mode == c_MODE_MEM) || (req_mode == c_MODE_RMW);

    // DONE doubles as an accepting state so a new request can follow with no idle gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_op          <= 4'd0;
            r_a           <= 8'd0;
            r_imm         <= 8'd0;
            r_mode        <= 2'd0;
            r_addr        <= 16'd0;
            r_mem_addr    <= 16'd0;
            r_mem_rd      <= 1'b0;
            r_mem_wr      <= 1'b0;
            r_mem_wdata   <= 8'd0;
            r_alu_op      <= 4'd0;
            r_alu_a       <= 8'd0;
            r_alu_b       <= 8'd0;
            r_alu_proceed <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= 8'd0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_op   <= req_op;
                        r_a    <= req_a;
                        r_imm  <= req_imm;
                        r_mode <= req_mode;
                        r_addr <= req_addr;
                        r_busy <= 1'b1;
                        if (w_req_is_mem) begin
                            r_state    <= c_ST_READ;
                            r_mem_rd   <= 1'b1;
                            r_mem_addr <= req_addr;
                        end else begin
                            r_state       <= c_ST_EXEC;
                            r_alu_op      <= req_op;
                            r_alu_a       <= req_a;
                            r_alu_b       <= req_imm;
                            r_alu_proceed <= 1'b1;
                        end
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_READ: begin
                    if (mem_ready) begin
                        r_mem_rd      <= 1'b0;
                        r_alu_op      <= r_op;
                        r_alu_proceed <= 1'b1;
                        r_state       <= c_ST_EXEC;
                        if (r_mode == c_MODE_RMW) begin
                            r_alu_a <= mem_rdata;
                            r_alu_b <= r_imm;
                        end else begin
                            r_alu_a <= r_a;
                            r_alu_b <= mem_rdata;
                        end
                    end
                end

                c_ST_EXEC: begin
                    r_alu_proceed <= 1'b0;
                    r_state       <= c_ST_WAIT;
                end

                c_ST_WAIT: begin
                    r_result <= alu_out;
                    if (r_mode == c_MODE_RMW) begin
                        r_state     <= c_ST_WRITE;
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= alu_out;
                    end else begin
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end

                c_ST_WRITE: begin
                    if (mem_ready) begin
                        r_mem_wr <= 1'b0;
                        r_state  <= c_ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end

                default: begin
                    r_state       <= c_ST_IDLE;
                    r_mem_rd      <= 1'b0;
                    r_mem_wr      <= 1'b0;
                    r_alu_proceed <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = r_mem_addr;
    assign mem_rd      = r_mem_rd;
    assign mem_wr      = r_mem_wr;
    assign mem_wdata   = r_mem_wdata;
    assign alu_op      = r_alu_op;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_proceed = r_alu_proceed;
    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;

endmodule
`default_nettype wire

// File: tb/tb_m6502_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_m6502_alu_seq
//  Purpose  : Self-checking bench for m6502_alu_seq with ALU and memory models.
//  Revision : 1.0
// ============================================================================
module tb_m6502_alu_seq;

    localparam logic [3:0] c_OP_ADC = 4'd1;
    localparam logic [3:0] c_OP_AND = 4'd2;
    localparam logic [3:0] c_OP_INC = 4'd3;
    localparam logic [3:0] c_OP_UPD = 4'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  req_op = 4'd0;
    logic [7:0]  req_a = 8'd0;
    logic [7:0]  req_imm = 8'd0;
    logic [1:0]  req_mode = 2'd0;
    logic [15:0] req_addr = 16'd0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_proceed;
    logic [7:0]  alu_out = 8'd0;
    logic        busy;
    logic        done;
    logic [7:0]  result;

    logic        alu_z = 1'b0;
    logic [7:0]  mem [0:65535];
    int          rd_delay = 0;
    int          wr_delay = 0;
    int          acc_cnt = 0;
    int          pulse_cnt = 0;
    int          rd_cycles = 0;
    int          wr_cnt = 0;
    logic [15:0] last_wr_addr = 16'd0;
    logic [7:0]  last_wr_data = 8'd0;
    logic        prev_proceed = 1'b0;
    logic        b2b_err = 1'b0;
    logic        overlap_err = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  sb [$];

    m6502_alu_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_imm     (req_imm),
        .req_mode    (req_mode),
        .req_addr    (req_addr),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_proceed (alu_proceed),
        .alu_out     (alu_out),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    always #5 clk = ~clk;

    assign mem_ready = (mem_rd && (acc_cnt >= rd_delay)) || (mem_wr && (acc_cnt >= wr_delay));
    assign mem_rdata = mem_rd ? mem[mem_addr] : 8'h00;

    // ALU model: carry-in is 0; acts on the cycle alu_proceed is high.
    always @(posedge clk) begin
        if (alu_proceed) begin
            case (alu_op)
                c_OP_ADC: begin alu_out <= alu_a + alu_b; alu_z <= ((alu_a + alu_b) & 8'hFF) == 0; end
                c_OP_AND: begin alu_out <= alu_a & alu_b; alu_z <= (alu_a & alu_b) == 8'h00; end
                c_OP_INC: begin alu_out <= alu_a + 8'd1;  alu_z <= (alu_a == 8'hFF); end
                default:  begin alu_out <= alu_a;         alu_z <= (alu_a == 8'h00); end
            endcase
        end
    end

    always @(posedge clk) begin
        if (mem_rd && mem_wr) overlap_err <= 1'b1;
        if (alu_proceed && prev_proceed) b2b_err <= 1'b1;
        if (alu_proceed && !prev_proceed) pulse_cnt <= pulse_cnt + 1;
        prev_proceed <= alu_proceed;
        if (mem_rd) rd_cycles <= rd_cycles + 1;
        if ((mem_rd || mem_wr) && !mem_ready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (mem_wr && mem_ready) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    task automatic launch(input logic [3:0] op, input logic [7:0] a, input logic [7:0] imm,
                          input logic [1:0] mode, input logic [15:0] addr, input logic [7:0] exp_res);
        req_op   = op;
        req_a    = a;
        req_imm  = imm;
        req_mode = mode;
        req_addr = addr;
        start    = 1'b1;
        sb.push_back(exp_res);
    endtask

    // Drops start and scrambles the request right after acceptance.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start    = 1'b0;
                req_a    = ~req_a;
                req_imm  = ~req_imm;
                req_addr = ~req_addr;
                req_op   = 4'hF;
            end
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if ({busy, done, alu_proceed, mem_rd, mem_wr} !== 5'b0)
            $display("FAIL reset_ctl: got %b expected 00000", {busy, done, alu_proceed, mem_rd, mem_wr});
        else n_pass++;
        n_chk++;
        if ({result, alu_op, alu_a, alu_b, mem_addr, mem_wdata} !== 52'd0)
            $display("FAIL reset_data: got %h expected 0", {result, alu_op, alu_a, alu_b, mem_addr, mem_wdata});
        else n_pass++;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || alu_proceed !== 1'b0)
            $display("FAIL reset_hold: got busy=%b proceed=%b expected 0 0", busy, alu_proceed);
        else n_pass++;
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reg_adc;
        int lat;
        int p0;
        logic [7:0] exp;
        p0 = pulse_cnt;
        launch(c_OP_ADC, 8'h10, 8'h22, 2'd0, 16'h1234, 8'h32);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 3) $display("FAIL reg_latency: got %0d expected 3", lat);
        else n_pass++;
        n_chk++;
        if (result !== exp) $display("FAIL reg_result: got %h expected %h", result, exp);
        else n_pass++;
        n_chk++;
        if (alu_a !== 8'h10 || alu_b !== 8'h22 || alu_op !== c_OP_ADC)
            $display("FAIL reg_operands: got op=%h a=%h b=%h expected op=%h a=10 b=22", alu_op, alu_a, alu_b, c_OP_ADC);
        else n_pass++;
        n_chk++;
        if (pulse_cnt - p0 !== 1) $display("FAIL reg_pulses: got %0d expected 1", pulse_cnt - p0);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mem_and;
        int lat;
        int r0;
        logic [7:0] exp;
        mem[16'h0200] = 8'h3C;
        rd_delay = 2;
        r0 = rd_cycles;
        launch(c_OP_AND, 8'hF0, 8'h99, 2'd1, 16'h0200, 8'h30);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 6) $display("FAIL mem_latency: got %0d expected 6", lat);
        else n_pass++;
        n_chk++;
        if (result !== exp) $display("FAIL mem_result: got %h expected %h", result, exp);
        else n_pass++;
        n_chk++;
        if (rd_cycles - r0 !== 3) $display("FAIL mem_rd_cycles: got %0d expected 3", rd_cycles - r0);
        else n_pass++;
        n_chk++;
        if (alu_a !== 8'hF0 || alu_b !== 8'h3C)
            $display("FAIL mem_operands: got a=%h b=%h expected a=f0 b=3c", alu_a, alu_b);
        else n_pass++;
        rd_delay = 0;
        @(negedge clk);
    endtask

    task automatic test_rmw_inc;
        int lat;
        int w0;
        logic [7:0] exp;
        mem[16'h0010] = 8'hFF;
        w0 = wr_cnt;
        launch(c_OP_INC, 8'h77, 8'h00, 2'd2, 16'h0010, 8'h00);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 5) $display("FAIL rmw_latency: got %0d expected 5", lat);
        else n_pass++;
        n_chk++;
        if (result !== exp) $display("FAIL rmw_result: got %h expected %h", result, exp);
        else n_pass++;
        n_chk++;
        if (wr_cnt - w0 !== 1 || last_wr_addr !== 16'h0010 || last_wr_data !== 8'h00)
            $display("FAIL rmw_write: got n=%0d addr=%h data=%h expected n=1 addr=0010 data=00",
                     wr_cnt - w0, last_wr_addr, last_wr_data);
        else n_pass++;
        n_chk++;
        if (alu_z !== 1'b1) $display("FAIL rmw_zflag: got %b expected 1", alu_z);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int p0;
        int extra_done;
        logic [7:0] exp;
        p0 = pulse_cnt;
        launch(c_OP_ADC, 8'h01, 8'h02, 2'd0, 16'h0000, 8'h03);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 3 || result !== exp)
            $display("FAIL b2b_first: got lat=%0d res=%h expected lat=3 res=%h", lat, result, exp);
        else n_pass++;
        launch(c_OP_AND, 8'hF0, 8'h3C, 2'd0, 16'h0000, 8'h30);
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b1 || done !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
        else n_pass++;
        req_op = c_OP_UPD;
        req_a  = 8'h77;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (done !== 1'b1 || result !== exp)
            $display("FAIL b2b_second: got done=%b res=%h expected done=1 res=%h", done, result, exp);
        else n_pass++;
        extra_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
        end
        n_chk++;
        if (extra_done !== 0 || pulse_cnt - p0 !== 2)
            $display("FAIL b2b_ignored: got dones=%0d pulses=%0d expected 0 2", extra_done, pulse_cnt - p0);
        else n_pass++;
        n_chk++;
        if (b2b_err !== 1'b0) $display("FAIL b2b_gap: got %b expected 0", b2b_err);
        else n_pass++;
    endtask

    task automatic test_reset_write;
        int lat;
        int w0;
        int seen;
        logic [7:0] exp;
        mem[16'h0010] = 8'h41;
        wr_delay = 20;
        w0 = wr_cnt;
        launch(c_OP_INC, 8'h00, 8'h00, 2'd2, 16'h0010, 8'h42);
        seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (mem_wr === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_chk++;
        if (seen !== 1) $display("FAIL rstw_reach_write: got %0d expected 1", seen);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (mem_wr !== 1'b0 || busy !== 1'b0 || result !== 8'h00)
            $display("FAIL rstw_abort: got wr=%b busy=%b res=%h expected 0 0 00", mem_wr, busy, result);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        void'(sb.pop_back());
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        n_chk++;
        if (seen !== 0 || wr_cnt - w0 !== 0)
            $display("FAIL rstw_nodone: got dones=%0d writes=%0d expected 0 0", seen, wr_cnt - w0);
        else n_pass++;
        wr_delay = 0;
        launch(c_OP_UPD, 8'h5A, 8'h00, 2'd0, 16'h0000, 8'h5A);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 3 || result !== exp)
            $display("FAIL rstw_next: got lat=%0d res=%h expected lat=3 res=%h", lat, result, exp);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_mode3;
        int lat;
        int r0;
        logic [7:0] exp;
        r0 = rd_cycles;
        launch(c_OP_UPD, 8'h9A, 8'h55, 2'd3, 16'h0200, 8'h9A);
        wait_done(lat);
        exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        n_chk++;
        if (lat !== 3 || result !== exp)
            $display("FAIL mode3: got lat=%0d res=%h expected lat=3 res=%h", lat, result, exp);
        else n_pass++;
        n_chk++;
        if (rd_cycles - r0 !== 0 || alu_b !== 8'h55)
            $display("FAIL mode3_nord: got rd=%0d b=%h expected 0 55", rd_cycles - r0, alu_b);
        else n_pass++;
        n_chk++;
        if (overlap_err !== 1'b0) $display("FAIL rd_wr_overlap: got %b expected 0", overlap_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reg_adc();
        test_mem_and();
        test_rmw_inc();
        test_back_to_back();
        test_reset_write();
        test_mode3();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
